// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ---------------------------------------------------------------------------
// Combined VGA timing generator: pixel-enable divider plus horizontal and
// vertical counters, all clocked from one system clock. Start/stop requests
// are frame-aligned, so the display never sees a truncated frame.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         run request, level-sensitive, sampled every clk
//   pix_tick   one-clk strobe per pixel period (held high when CLK_DIV = 1)
//   hsync      horizontal sync, active level H_POL
//   vsync      vertical sync, active level V_POL
//   de         display enable (visible region)
//   h_pos      current pixel column
//   v_pos      current line
//   new_line   one-clk pulse when h_pos becomes 0
//   new_frame  one-clk pulse when (h_pos, v_pos) becomes (0, 0)
//   vblank     high while v_pos >= V_DISPLAY
//   frame_cnt  frames started, modulo 2^FCW
//   running    high while the generator is producing timing
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int FCW       = 8,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] h_pos,
  output logic [VW-1:0] v_pos,
  output logic          new_line,
  output logic          new_frame,
  output logic          vblank,
  output logic [FCW-1:0] frame_cnt,
  output logic          running
);

  if (CLK_DIV < 1 || H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: CLK_DIV and all H_*/V_* timing parameters must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP       = HW'(H_DISPLAY);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP       = VW'(V_DISPLAY);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  state_t          state_q, state_n;
  logic [DW-1:0]   div_q, div_n;
  logic [HW-1:0]   h_n;
  logic [VW-1:0]   v_n;
  logic            tick, line_n, frame_n, run_n;

  // Next-state computation for the FSM, divider and both counters. All
  // registered outputs below are decoded from these next values so that
  // position, syncs and enables always describe the same pixel.
  // A STOP only turns into IDLE on the pixel that would wrap the frame,
  // and an en request seen on that same clk keeps the frame going.
  always_comb begin
    tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    state_n = state_q;
    div_n   = div_q;
    h_n     = h_pos;
    v_n     = v_pos;
    line_n  = 1'b0;
    frame_n = 1'b0;
    case (state_q)
      IDLE: begin
        div_n = '0;
        h_n   = '0;
        v_n   = '0;
        if (en) begin
          state_n = RUN;
          line_n  = 1'b1;
          frame_n = 1'b1;
        end
      end
      RUN, STOP: begin
        state_n = en ? RUN : STOP;
        div_n   = tick ? '0 : div_q + DW'(1);
        if (tick) begin
          if (h_pos == H_LAST && v_pos == V_LAST && state_q == STOP && !en) begin
            state_n = IDLE;
            div_n   = '0;
            h_n     = '0;
            v_n     = '0;
          end else if (h_pos == H_LAST) begin
            h_n    = '0;
            line_n = 1'b1;
            if (v_pos == V_LAST) begin
              v_n     = '0;
              frame_n = 1'b1;
            end else begin
              v_n = v_pos + VW'(1);
            end
          end else begin
            h_n = h_pos + HW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    run_n = (state_n != IDLE);
  end

  // State, counters and all outputs are registered together; idle forces the
  // decoded outputs to their inactive levels while frame_cnt keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      h_pos     <= '0;
      v_pos     <= '0;
      frame_cnt <= '0;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      de        <= 1'b0;
      vblank    <= 1'b0;
      new_line  <= 1'b0;
      new_frame <= 1'b0;
      pix_tick  <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      h_pos     <= h_n;
      v_pos     <= v_n;
      frame_cnt <= frame_n ? frame_cnt + FCW'(1) : frame_cnt;
      hsync     <= (run_n && h_n >= H_SYNC_START && h_n < H_SYNC_END) ? H_POL : ~H_POL;
      vsync     <= (run_n && v_n >= V_SYNC_START && v_n < V_SYNC_END) ? V_POL : ~V_POL;
      de        <= run_n && (h_n < H_DISP) && (v_n < V_DISP);
      vblank    <= run_n && (v_n >= V_DISP);
      new_line  <= line_n;
      new_frame <= frame_n;
      pix_tick  <= run_n && (div_n == DIV_LAST);
      running   <= run_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// ---------------------------------------------------------------------------
// Two instances share clock and reset: a small configuration (8x6 frame,
// CLK_DIV = 1, FCW = 2) exercised with directed and random en patterns, and
// the default 640x480 configuration run continuously for a couple of lines.
// Expected values come from a frame-level model: the small frame is a linear
// pixel index 0..47, the default one a clock count since start.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_s, en_d;

  logic       s_pix_tick, s_hsync, s_vsync, s_de, s_new_line, s_new_frame, s_vblank, s_running;
  logic [2:0] s_h_pos, s_v_pos;
  logic [1:0] s_frame_cnt;

  logic       d_pix_tick, d_hsync, d_vsync, d_de, d_new_line, d_new_frame, d_vblank, d_running;
  logic [9:0] d_h_pos, d_v_pos;
  logic [7:0] d_frame_cnt;

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FCW(2)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en_s), .pix_tick(s_pix_tick), .hsync(s_hsync),
    .vsync(s_vsync), .de(s_de), .h_pos(s_h_pos), .v_pos(s_v_pos), .new_line(s_new_line),
    .new_frame(s_new_frame), .vblank(s_vblank), .frame_cnt(s_frame_cnt), .running(s_running)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .en(en_d), .pix_tick(d_pix_tick), .hsync(d_hsync),
    .vsync(d_vsync), .de(d_de), .h_pos(d_h_pos), .v_pos(d_v_pos), .new_line(d_new_line),
    .new_frame(d_new_frame), .vblank(d_vblank), .frame_cnt(d_frame_cnt), .running(d_running)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Small-config model: active flag, pixel index within the 48-pixel frame,
  // whether en was low on the previous edge (a pending stop), pulses, frames.
  bit mActive, mPrevEn, mNl, mNf;
  int mPix, mFc;
  // Default-config model: clocks since start and frames started.
  bit dActive;
  int dT, dFc;
  int deCnt, hsLowCnt;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checkCount++;
    if (obs == exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
  endtask

  task automatic modelReset();
    mActive = 0; mPrevEn = 0; mNl = 0; mNf = 0; mPix = 0; mFc = 0;
    dActive = 0; dT = 0; dFc = 0;
  endtask

  task automatic modelStep(input logic e_s, input logic e_d);
    mNl = 0; mNf = 0;
    if (!mActive) begin
      if (e_s) begin
        mActive = 1; mPix = 0; mNl = 1; mNf = 1; mFc = (mFc + 1) % 4;
      end
    end else if (mPix == 47 && !mPrevEn && !e_s) begin
      mActive = 0; mPix = 0;
    end else begin
      mPix = (mPix + 1) % 48;
      mNl  = (mPix % 8 == 0);
      mNf  = (mPix == 0);
      if (mNf) mFc = (mFc + 1) % 4;
    end
    mPrevEn = e_s;
    if (!dActive) begin
      if (e_d) begin
        dActive = 1; dT = 0; dFc = (dFc + 1) % 256;
      end
    end else begin
      dT++;
      if (dT % 840000 == 0) dFc = (dFc + 1) % 256;
    end
  endtask

  task automatic checkAll();
    int h, v, px;
    h = mActive ? mPix % 8 : 0;
    v = mActive ? mPix / 8 : 0;
    checkOutput("s_h_pos", s_h_pos, h);
    checkOutput("s_v_pos", s_v_pos, v);
    checkOutput("s_running", s_running, mActive);
    checkOutput("s_pix_tick", s_pix_tick, mActive);
    checkOutput("s_de", s_de, mActive && h < 4 && v < 3);
    checkOutput("s_hsync", s_hsync, !(mActive && h >= 5 && h <= 6));
    checkOutput("s_vsync", s_vsync, !(mActive && v == 4));
    checkOutput("s_vblank", s_vblank, mActive && v >= 3);
    checkOutput("s_new_line", s_new_line, mNl);
    checkOutput("s_new_frame", s_new_frame, mNf);
    checkOutput("s_frame_cnt", s_frame_cnt, mFc);
    px = dActive ? dT / 2 : 0;
    h  = px % 800;
    v  = (px / 800) % 525;
    checkOutput("d_h_pos", d_h_pos, h);
    checkOutput("d_v_pos", d_v_pos, v);
    checkOutput("d_running", d_running, dActive);
    checkOutput("d_pix_tick", d_pix_tick, dActive && (dT % 2 == 1));
    checkOutput("d_de", d_de, dActive && h < 640 && v < 480);
    checkOutput("d_hsync", d_hsync, !(dActive && h >= 656 && h < 752));
    checkOutput("d_vsync", d_vsync, !(dActive && v >= 490 && v < 492));
    checkOutput("d_vblank", d_vblank, dActive && v >= 480);
    checkOutput("d_new_line", d_new_line, dActive && (dT % 1600 == 0));
    checkOutput("d_new_frame", d_new_frame, dActive && (dT % 840000 == 0));
    checkOutput("d_frame_cnt", d_frame_cnt, dFc);
  endtask

  // One clock: drive en mid-cycle, advance the model on the edge, check 1 ns later.
  task automatic applyStimulus(input logic e_s, input logic e_d);
    #4;
    en_s = e_s;
    en_d = e_d;
    @(posedge clk);
    modelStep(e_s, e_d);
    #1;
    checkAll();
    if (dActive && dT < 1600) begin
      deCnt    += int'(d_de);
      hsLowCnt += int'(!d_hsync);
      if (dT == 1599) begin
        checkOutput("d_de_clks_line0", deCnt, 1280);
        checkOutput("d_hsync_low_clks", hsLowCnt, 192);
      end
    end
  endtask

  task automatic runTo(input int target, input logic e_s);
    int guard = 0;
    while (!(mActive && mPix == target) && guard < 200) begin
      applyStimulus(e_s, 1'b1);
      guard++;
    end
    if (guard >= 200) checkOutput("runTo_timeout", 0, 1);
  endtask

  task automatic runUntilIdle();
    int guard = 0;
    while (mActive && guard < 200) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 200) checkOutput("idle_timeout", 0, 1);
  endtask

  initial begin
    logic e;
    rst_n = 1'b0; en_s = 1'b0; en_d = 1'b0;
    deCnt = 0; hsLowCnt = 0;
    modelReset();
    @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;

    // Idle with en low, then the default instance starts at cycle 26.
    repeat (25) applyStimulus(1'b0, 1'b0);

    // Five uninterrupted small frames, then a frame-aligned stop.
    repeat (240) applyStimulus(1'b1, 1'b1);
    runUntilIdle();
    repeat (3) applyStimulus(1'b0, 1'b1);

    // Drop en at (2,1): finish the frame, then idle with no new_frame.
    runTo(10, 1'b1);
    runUntilIdle();
    repeat (5) applyStimulus(1'b0, 1'b1);

    // Drop and re-raise before the wrap: timing must not break.
    runTo(20, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);
    repeat (40) applyStimulus(1'b1, 1'b1);

    // Re-raise en exactly on the wrap clk of a stopping frame.
    runTo(45, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b1);

    // Random en with persistence.
    e = 1'b1;
    repeat (2000) begin
      if ($urandom_range(0, 19) == 0) e = ~e;
      applyStimulus(e, 1'b1);
    end

    // Asynchronous reset mid-line at (3,2), between clock edges.
    runTo(19, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    rst_n = 1'b1;
    repeat (20) applyStimulus(1'b1, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
